// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and flush controller for the swt16 pipeline.
//   Tracks in-flight loads in a LOAD_LAT-deep scoreboard and raises load-use
//   interlocks, holds the front end while EX is busy, and sequences a
//   FLUSH_FE_CYCLES-long fetch flush after a branch redirect.
//   Optional macro PIPE_CTRL_PERF_EN builds saturating performance counters;
//   without it the perf ports are tied to 0.
// Ports:
//   clock, reset                 clock, asynchronous active-high reset
//   in_dc_*                      decode-stage instruction operands / load flag
//   in_ex_busy                   EX requests another cycle
//   in_redirect, in_redirect_pc  taken branch / jump from EX
//   out_stall_*, out_bubble_*    stall and NOP-injection controls
//   out_flush_fe, out_flush_dc   pipeline register invalidation
//   out_set_pc, out_branch_pc    PC redirect
//   out_perf_*                   stall-cycle and redirect counters
module pipe_ctrl #(
    parameter int unsigned REG_IDX_WIDTH   = 4,
    parameter int unsigned PC_WIDTH        = 12,
    parameter int unsigned LOAD_LAT        = 1,
    parameter int unsigned FLUSH_FE_CYCLES = 2,
    parameter int unsigned PERF_WIDTH      = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_dc_valid,
    input  logic [REG_IDX_WIDTH-1:0] in_dc_src1_idx,
    input  logic                     in_dc_src1_used,
    input  logic [REG_IDX_WIDTH-1:0] in_dc_src2_idx,
    input  logic                     in_dc_src2_used,
    input  logic [REG_IDX_WIDTH-1:0] in_dc_dst_idx,
    input  logic                     in_dc_is_load,
    input  logic                     in_ex_busy,
    input  logic                     in_redirect,
    input  logic [PC_WIDTH-1:0]      in_redirect_pc,
    output logic                     out_stall_fe,
    output logic                     out_stall_dc,
    output logic                     out_stall_ex,
    output logic                     out_bubble_ex,
    output logic                     out_bubble_mem,
    output logic                     out_flush_fe,
    output logic                     out_flush_dc,
    output logic                     out_set_pc,
    output logic [PC_WIDTH-1:0]      out_branch_pc,
    output logic [PERF_WIDTH-1:0]    out_perf_stall_cycles,
    output logic [PERF_WIDTH-1:0]    out_perf_flush_events
);

    localparam int unsigned CNT_W = (FLUSH_FE_CYCLES > 1) ? $clog2(FLUSH_FE_CYCLES) : 1;

    logic [LOAD_LAT-1:0]                    sb_vld_q, sb_vld_d;
    logic [LOAD_LAT-1:0][REG_IDX_WIDTH-1:0] sb_idx_q, sb_idx_d;
    logic [CNT_W-1:0]                       flush_cnt_q, flush_cnt_d;

    logic redirect;
    logic match;
    logic hazard;

    // Hazard detection and priority: redirect > ex_busy > load-use.
    always_comb begin
        redirect = in_redirect & ~in_ex_busy;
        match    = 1'b0;
        for (int unsigned i = 0; i < LOAD_LAT; i++) begin
            if (sb_vld_q[i] &&
                ((in_dc_src1_used && (sb_idx_q[i] == in_dc_src1_idx)) ||
                 (in_dc_src2_used && (sb_idx_q[i] == in_dc_src2_idx)))) begin
                match = 1'b1;
            end
        end
        hazard = in_dc_valid & ~redirect & ~in_ex_busy & match;
    end

    // Scoreboard shift (held while EX is busy) and flush counter sequencing.
    always_comb begin
        sb_vld_d    = sb_vld_q;
        sb_idx_d    = sb_idx_q;
        flush_cnt_d = flush_cnt_q;
        if (!in_ex_busy) begin
            for (int unsigned i = 1; i < LOAD_LAT; i++) begin
                sb_vld_d[i] = sb_vld_q[i-1];
                sb_idx_d[i] = sb_idx_q[i-1];
            end
            // A redirected or interlocked DC instruction must not be tracked.
            sb_vld_d[0] = in_dc_valid & in_dc_is_load & ~hazard & ~redirect;
            sb_idx_d[0] = in_dc_dst_idx;
        end
        if (redirect) begin
            flush_cnt_d = CNT_W'(FLUSH_FE_CYCLES - 1);
        end else if (flush_cnt_q != '0) begin
            flush_cnt_d = flush_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sb_vld_q    <= '0;
            sb_idx_q    <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_vld_q    <= sb_vld_d;
            sb_idx_q    <= sb_idx_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Same-cycle control outputs; forced low while reset is asserted.
    always_comb begin
        out_stall_fe   = ~reset & (in_ex_busy | hazard);
        out_stall_dc   = ~reset & (in_ex_busy | hazard);
        out_stall_ex   = ~reset & in_ex_busy;
        out_bubble_mem = ~reset & in_ex_busy;
        out_bubble_ex  = ~reset & hazard;
        out_flush_fe   = ~reset & (redirect | (flush_cnt_q != '0));
        out_flush_dc   = ~reset & redirect;
        out_set_pc     = ~reset & redirect;
        out_branch_pc  = (~reset & redirect) ? in_redirect_pc : '0;
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_WIDTH-1:0] flush_ev_q, flush_ev_d;

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_ev_d  = flush_ev_q;
        if (out_stall_fe && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + PERF_WIDTH'(1);
        end
        if (out_set_pc && (flush_ev_q != '1)) begin
            flush_ev_d = flush_ev_q + PERF_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_ev_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_ev_q  <= flush_ev_d;
        end
    end

    assign out_perf_stall_cycles = stall_cnt_q;
    assign out_perf_flush_events = flush_ev_q;
`else
    assign out_perf_stall_cycles = '0;
    assign out_perf_flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl. Two instances
// (LOAD_LAT=1 and LOAD_LAT=2) share the same stimulus; each vector carries
// hand-computed control outputs for both. PIPE_CTRL_PERF_EN selects whether
// the perf counters are expected to count or to stay at 0.
module tb_pipe_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_dc_valid;
    logic [3:0]  in_dc_src1_idx;
    logic        in_dc_src1_used;
    logic [3:0]  in_dc_src2_idx;
    logic        in_dc_src2_used;
    logic [3:0]  in_dc_dst_idx;
    logic        in_dc_is_load;
    logic        in_ex_busy;
    logic        in_redirect;
    logic [11:0] in_redirect_pc;

    logic        s_fe1, s_dc1, s_ex1, b_ex1, b_mem1, f_fe1, f_dc1, set1;
    logic        s_fe2, s_dc2, s_ex2, b_ex2, b_mem2, f_fe2, f_dc2, set2;
    logic [11:0] pc1, pc2;
    logic [15:0] ps1, pf1, ps2, pf2;

    always #5 clock = ~clock;

    pipe_ctrl #(.LOAD_LAT(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .in_dc_valid(in_dc_valid), .in_dc_src1_idx(in_dc_src1_idx),
        .in_dc_src1_used(in_dc_src1_used), .in_dc_src2_idx(in_dc_src2_idx),
        .in_dc_src2_used(in_dc_src2_used), .in_dc_dst_idx(in_dc_dst_idx),
        .in_dc_is_load(in_dc_is_load), .in_ex_busy(in_ex_busy),
        .in_redirect(in_redirect), .in_redirect_pc(in_redirect_pc),
        .out_stall_fe(s_fe1), .out_stall_dc(s_dc1), .out_stall_ex(s_ex1),
        .out_bubble_ex(b_ex1), .out_bubble_mem(b_mem1),
        .out_flush_fe(f_fe1), .out_flush_dc(f_dc1),
        .out_set_pc(set1), .out_branch_pc(pc1),
        .out_perf_stall_cycles(ps1), .out_perf_flush_events(pf1)
    );

    pipe_ctrl #(.LOAD_LAT(2)) u_dut2 (
        .clock(clock), .reset(reset),
        .in_dc_valid(in_dc_valid), .in_dc_src1_idx(in_dc_src1_idx),
        .in_dc_src1_used(in_dc_src1_used), .in_dc_src2_idx(in_dc_src2_idx),
        .in_dc_src2_used(in_dc_src2_used), .in_dc_dst_idx(in_dc_dst_idx),
        .in_dc_is_load(in_dc_is_load), .in_ex_busy(in_ex_busy),
        .in_redirect(in_redirect), .in_redirect_pc(in_redirect_pc),
        .out_stall_fe(s_fe2), .out_stall_dc(s_dc2), .out_stall_ex(s_ex2),
        .out_bubble_ex(b_ex2), .out_bubble_mem(b_mem2),
        .out_flush_fe(f_fe2), .out_flush_dc(f_dc2),
        .out_set_pc(set2), .out_branch_pc(pc2),
        .out_perf_stall_cycles(ps2), .out_perf_flush_events(pf2)
    );

    // Control vector: {stall_fe, stall_dc, stall_ex, bubble_ex, bubble_mem, flush_fe, flush_dc, set_pc}
    localparam logic [7:0] N  = 8'h00;
    localparam logic [7:0] LU = 8'hD0;
    localparam logic [7:0] BZ = 8'hE8;
    localparam logic [7:0] RD = 8'h07;
    localparam logic [7:0] FF = 8'h04;

    typedef struct {
        logic       rst, dv;
        logic [3:0] s1;
        logic       s1u;
        logic [3:0] s2;
        logic       s2u;
        logic [3:0] dst;
        logic       ld, busy, redir;
        logic [11:0] rpc;
        logic [7:0] e1, e2;
    } vec_t;

    typedef struct {
        logic        rst;
        logic [11:0] rpc;
        logic [7:0]  e1, e2;
    } exp_t;

    vec_t vecs[$];
    exp_t expq[$];

    int errors = 0;
    int checks = 0;
    int st1 = 0, st2 = 0, fl = 0;

    task automatic add(input logic rst, input logic dv, input logic [3:0] s1, input logic s1u,
                       input logic [3:0] s2, input logic s2u, input logic [3:0] dst,
                       input logic ld, input logic busy, input logic redir,
                       input logic [11:0] rpc, input logic [7:0] e1, input logic [7:0] e2);
        vec_t v;
        v.rst = rst; v.dv = dv; v.s1 = s1; v.s1u = s1u; v.s2 = s2; v.s2u = s2u;
        v.dst = dst; v.ld = ld; v.busy = busy; v.redir = redir; v.rpc = rpc;
        v.e1 = e1; v.e2 = e2;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clock) begin
        assert (!(in_redirect && in_ex_busy)) else $error("redirect raised together with ex_busy");
    end

    // Monitor: one expected response per cycle, sampled mid-cycle.
    always @(negedge clock) begin
        if (expq.size() > 0) begin
            exp_t e;
            logic [31:0] eps1, eps2, epf;
            e = expq.pop_front();
`ifdef PIPE_CTRL_PERF_EN
            eps1 = e.rst ? 32'd0 : 32'(st1);
            eps2 = e.rst ? 32'd0 : 32'(st2);
            epf  = e.rst ? 32'd0 : 32'(fl);
`else
            eps1 = 32'd0;
            eps2 = 32'd0;
            epf  = 32'd0;
`endif
            chk("ctrl_lat1", 32'({s_fe1, s_dc1, s_ex1, b_ex1, b_mem1, f_fe1, f_dc1, set1}), 32'(e.e1));
            chk("ctrl_lat2", 32'({s_fe2, s_dc2, s_ex2, b_ex2, b_mem2, f_fe2, f_dc2, set2}), 32'(e.e2));
            chk("branch_pc_lat1", 32'(pc1), e.e1[0] ? 32'(e.rpc) : 32'd0);
            chk("branch_pc_lat2", 32'(pc2), e.e2[0] ? 32'(e.rpc) : 32'd0);
            chk("perf_stall_lat1", 32'(ps1), eps1);
            chk("perf_stall_lat2", 32'(ps2), eps2);
            chk("perf_flush_lat1", 32'(pf1), epf);
            chk("perf_flush_lat2", 32'(pf2), epf);
            if (e.rst) begin
                st1 = 0; st2 = 0; fl = 0;
            end else begin
                st1 += int'(e.e1[7]);
                st2 += int'(e.e2[7]);
                fl  += int'(e.e1[0]);
            end
        end
    end

    initial begin
        reset = 1'b1;
        in_dc_valid = 1'b0; in_dc_src1_idx = '0; in_dc_src1_used = 1'b0;
        in_dc_src2_idx = '0; in_dc_src2_used = 1'b0; in_dc_dst_idx = '0;
        in_dc_is_load = 1'b0; in_ex_busy = 1'b0; in_redirect = 1'b0; in_redirect_pc = '0;

        //  rst dv s1 u  s2 u  dst ld bsy red rpc     lat1 lat2
        add(1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 12'h000, N,  N );
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 12'h000, N,  N );
        // load r3 then consumer on src2
        add(0, 1, 0, 0, 0, 0, 3,  1, 0, 0, 12'h000, N,  N );
        add(0, 1, 5, 1, 3, 1, 4,  0, 0, 0, 12'h000, LU, LU);
        add(0, 1, 5, 1, 3, 1, 4,  0, 0, 0, 12'h000, N,  LU);
        add(0, 1, 5, 1, 3, 1, 4,  0, 0, 0, 12'h000, N,  N );
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 12'h000, N,  N );
        // load r7, independent op, consumer
        add(0, 1, 0, 0, 0, 0, 7,  1, 0, 0, 12'h000, N,  N );
        add(0, 1, 1, 1, 2, 1, 8,  0, 0, 0, 12'h000, N,  N );
        add(0, 1, 7, 1, 7, 0, 9,  0, 0, 0, 12'h000, N,  LU);
        add(0, 1, 7, 1, 7, 0, 9,  0, 0, 0, 12'h000, N,  N );
        // unused sources and invalid DC never interlock
        add(0, 1, 0, 0, 0, 0, 9,  1, 0, 0, 12'h000, N,  N );
        add(0, 1, 9, 0, 9, 0, 1,  0, 0, 0, 12'h000, N,  N );
        add(0, 0, 9, 1, 9, 1, 1,  0, 0, 0, 12'h000, N,  N );
        // register 0 is tracked like any other
        add(0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 12'h000, N,  N );
        add(0, 1, 0, 1, 0, 0, 2,  0, 0, 0, 12'h000, LU, LU);
        add(0, 1, 0, 1, 0, 0, 2,  0, 0, 0, 12'h000, N,  LU);
        add(0, 1, 0, 1, 0, 0, 2,  0, 0, 0, 12'h000, N,  N );
        // single redirect, then back-to-back redirects
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 12'h0A4, RD, RD);
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 12'h000, FF, FF);
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 12'h000, N,  N );
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 12'h0A4, RD, RD);
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 12'h123, RD, RD);
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 12'h000, FF, FF);
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 12'h000, N,  N );
        // ex_busy alone, then ex_busy masking a pending load-use
        add(0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 12'h000, BZ, BZ);
        add(0, 1, 0, 0, 0, 0, 5,  1, 0, 0, 12'h000, N,  N );
        add(0, 1, 5, 1, 0, 0, 6,  0, 1, 0, 12'h000, BZ, BZ);
        add(0, 1, 5, 1, 0, 0, 6,  0, 1, 0, 12'h000, BZ, BZ);
        add(0, 1, 5, 1, 0, 0, 6,  0, 1, 0, 12'h000, BZ, BZ);
        add(0, 1, 5, 1, 0, 0, 6,  0, 0, 0, 12'h000, LU, LU);
        add(0, 1, 5, 1, 0, 0, 6,  0, 0, 0, 12'h000, N,  LU);
        add(0, 1, 5, 1, 0, 0, 6,  0, 0, 0, 12'h000, N,  N );
        // redirect wins over a load-use match; the redirected load is not tracked
        add(0, 1, 0, 0, 0, 0, 6,  1, 0, 0, 12'h000, N,  N );
        add(0, 1, 6, 1, 0, 0, 10, 1, 0, 1, 12'h200, RD, RD);
        add(0, 1, 10,1, 0, 0, 1,  0, 0, 0, 12'h000, FF, FF);
        add(0, 1, 6, 1, 0, 0, 1,  0, 0, 0, 12'h000, N,  N );
        // reset mid-stall with live scoreboard entry and flush counter
        add(0, 1, 0, 0, 0, 0, 11, 1, 0, 0, 12'h000, N,  N );
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 12'h0FF, RD, RD);
        add(1, 1, 11,1, 0, 0, 1,  0, 0, 0, 12'h000, N,  N );
        add(0, 1, 11,1, 0, 0, 1,  0, 0, 0, 12'h000, N,  N );
        add(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 12'h000, N,  N );

        repeat (2) @(posedge clock);
        foreach (vecs[i]) begin
            exp_t e;
            @(posedge clock);
            #1;
            reset           = vecs[i].rst;
            in_dc_valid     = vecs[i].dv;
            in_dc_src1_idx  = vecs[i].s1;
            in_dc_src1_used = vecs[i].s1u;
            in_dc_src2_idx  = vecs[i].s2;
            in_dc_src2_used = vecs[i].s2u;
            in_dc_dst_idx   = vecs[i].dst;
            in_dc_is_load   = vecs[i].ld;
            in_ex_busy      = vecs[i].busy;
            in_redirect     = vecs[i].redir;
            in_redirect_pc  = vecs[i].rpc;
            e.rst = vecs[i].rst; e.rpc = vecs[i].rpc; e.e1 = vecs[i].e1; e.e2 = vecs[i].e2;
            expq.push_back(e);
        end

        for (int k = 0; k < 10 && expq.size() != 0; k++) @(posedge clock);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses left, expected 0", expq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Centralised hazard and flush controller for the next-generation swt16 pipeline. It replaces the ad-hoc flush/set_pc wiring between the exec and fetch stages. It tracks in-flight loads in a scoreboard shift register and raises load-use interlocks. It also holds the whole front end while EX runs a multi-cycle operation, and sequences a configurable multi-cycle fetch flush after a branch redirect.

Parameters:
REG_IDX_WIDTH, 4, register index width
PC_WIDTH, 12, program counter width
LOAD_LAT, 1, cycles (>=1) after a load leaves DC before its data is forwardable to DC; sets the scoreboard depth
FLUSH_FE_CYCLES, 2, cycles (>=1) for which fetch output is flushed after a redirect, covering synchronous PMEM read latency
PERF_WIDTH, 16, width of the performance counters

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_dc_valid  in  1  DC holds a valid instruction
in_dc_src1_idx  in  REG_IDX_WIDTH  DC source 1 register index
in_dc_src1_used  in  1  source 1 is read
in_dc_src2_idx  in  REG_IDX_WIDTH  DC source 2 register index
in_dc_src2_used  in  1  source 2 is read
in_dc_dst_idx  in  REG_IDX_WIDTH  DC destination register index
in_dc_is_load  in  1  DC instruction loads DMEM into dst
in_ex_busy  in  1  EX needs another cycle (multi-cycle op)
in_redirect  in  1  EX resolved a taken branch or jump
in_redirect_pc  in  PC_WIDTH  redirect target
out_stall_fe  out  1  hold PC and the IF/DC register
out_stall_dc  out  1  hold the DC/EX inputs
out_stall_ex  out  1  hold the EX stage
out_bubble_ex  out  1  inject a NOP into DC/EX
out_bubble_mem  out  1  inject a NOP into EX/MEM
out_flush_fe  out  1  invalidate the IF/DC register
out_flush_dc  out  1  invalidate the DC/EX register
out_set_pc  out  1  load PC with out_branch_pc
out_branch_pc  out  PC_WIDTH  redirect target
out_perf_stall_cycles  out  PERF_WIDTH  stall cycle counter
out_perf_flush_events  out  PERF_WIDTH  redirect counter

Behaviour:
- Reset:
  - Scoreboard (LOAD_LAT entries of {valid, idx}) is cleared.
  - Flush counter is set to 0; performance counters are set to 0.
  - While reset is high, all outputs are 0.
- Control outputs are combinational from the inputs and registered state, and act in the same cycle. State updates on the clock rising edge.
- Priority per cycle: redirect > ex_busy > load-use. in_redirect is ignored while in_ex_busy=1; a bench assertion checks that both are never high together.
- Redirect:
  - Same cycle: out_set_pc=1, out_branch_pc=in_redirect_pc, out_flush_fe=1, out_flush_dc=1.
  - Flush counter loads FLUSH_FE_CYCLES-1.
  - While the counter is >0: out_flush_fe=1 and the counter decrements each cycle.
  - A new redirect reloads the counter.
  - All stalls and bubbles are 0 in a redirect cycle.
  - out_branch_pc is 0 whenever out_set_pc=0.
- EX busy (no redirect): out_stall_fe=out_stall_dc=out_stall_ex=1 and out_bubble_mem=1. The scoreboard holds. Load-use detection is masked in this cycle.
- Load-use hazard:
  - Raised when in_dc_valid=1, no redirect, no ex_busy, and any valid scoreboard entry idx equals in_dc_src1_idx (with src1_used) or in_dc_src2_idx (with src2_used).
  - Response: out_stall_fe=out_stall_dc=1 and out_bubble_ex=1.
  - Register 0 is treated like any other index.
- Scoreboard shift (every cycle except ex_busy):
  - entry0 <= {in_dc_valid & in_dc_is_load & !hazard & !in_redirect, in_dc_dst_idx}.
  - entry k <= entry k-1; the last entry drops out.
  - On redirect, entry0 is written invalid.
- A flushed (in_dc_valid=0) DC never raises a hazard and never enters the scoreboard.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined:
  - out_perf_stall_cycles increments on every cycle with out_stall_fe=1.
  - out_perf_flush_events increments on every redirect cycle.
  - Both saturate at all-ones and never wrap.
- Undefined: both ports are constant 0 and no counter registers are built.

Test Plan:
- Reset asserted mid-stall (scoreboard entry valid, flush counter=1) -> all outputs 0 immediately; after release, a DC read of the same register causes no stall.
- LOAD_LAT=1: load r3, then in the next cycle add reading r3 as src2 -> exactly 1 cycle of out_stall_fe/out_stall_dc/out_bubble_ex=1, then flow resumes.
- LOAD_LAT=2: the same sequence -> 2 stall cycles; with one independent instruction in between -> 1 stall cycle.
- Redirect to 0x0A4 -> out_set_pc=1 and out_branch_pc=0x0A4 for 1 cycle, out_flush_dc for 1 cycle, out_flush_fe for 2 cycles; a second redirect in cycle 2 extends out_flush_fe to 2 cycles from that point.
- in_ex_busy high for 3 cycles while a load-use hazard is pending -> out_stall_ex/out_bubble_mem for 3 cycles, then 1 load-use stall cycle.
- Redirect coinciding with a load-use match -> no bubble and no stall; the scoreboard entry is not written; with PIPE_CTRL_PERF_EN, flush_events=1 and stall_cycles unchanged.
